mult_div_sequencer: RTL and testbench
=====================================

Name: mult_div_sequencer

Overview:
- Multi-cycle controller that runs MIPS MULT/MULTU/DIV/DIVU by driving the shared 32-bit ALU (ALU32Bit) for 32 iterations. Shift-and-add is used for multiply and restoring subtraction for divide.
- Sits beside the EX stage, owns the HI/LO result registers, and asserts AluReq while it drives the ALU inputs.
- Sign handling (abs/negate) is local; all 32-bit add/sub goes through the ALU.

Parameters:
- WIDTH, 32, operand width; only 32 is supported.
- ITER, 32, iteration count; must equal WIDTH.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  request pulse; sampled in IDLE/DONE only.
- Op  in  2  operation: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- OpA  in  32  multiplicand or dividend (rs).
- OpB  in  32  multiplier or divisor (rt).
- Busy  out  1  high in LOAD/RUN/FIX.
- Done  out  1  one-cycle pulse; HI/LO valid.
- DivZero  out  1  divide with OpB==0; valid with Done, held like HI/LO.
- Hi  out  32  HI register (product[63:32] or remainder).
- Lo  out  32  LO register (product[31:0] or quotient).
- AluReq  out  1  sequencer is driving the ALU this cycle.
- ALUControl  out  5  ALU opcode.
- ALUA  out  32  ALU A operand.
- ALUB  out  32  ALU B operand.
- ALUResult  in  32  ALU combinational result, same cycle.

Behaviour:
- **Reset:** Rst_n low asynchronously forces IDLE and clears all outputs and registers to 0, including mid-operation. In-flight work is discarded and no Done is issued.
- **States:** IDLE -> LOAD -> RUN -> FIX -> DONE -> IDLE. A Start in DONE goes directly to LOAD.
- **IDLE/DONE:**
  - If Start=1, capture Op, the signs of OpA/OpB, M/D = |OpB| and Q = |OpA|. Abs is applied only for Op[1]=1.
  - Start is ignored while Busy=1.
- **LOAD:** 1 cycle.
  - Multiply: Hi<=0, Lo<=Q.
  - Divide: Hi<=0, Lo<=Q.
  - Cnt<=0.
- **RUN:** 32 cycles, Cnt 0..31, AluReq=1.
  - Multiply step:
    - ALUControl=ADD (5'b00010), ALUA=Hi, ALUB=Lo[0]?M:0.
    - carry = (ALUResult < ALUA), unsigned local compare.
    - {Hi,Lo} <= {carry, ALUResult, Lo[31:1]}.
  - Divide step:
    - sh = {Hi, Lo[31]} (33 bits), ALUControl=SUB (5'b00110), ALUA=sh[31:0], ALUB=D.
    - ge = sh[32] | (ALUA >= D).
    - Hi <= ge ? ALUResult : ALUA; Lo <= {Lo[30:0], ge}.
  - Exit to FIX when Cnt==31.
- **FIX:** 1 cycle, AluReq=0.
  - MULT: negate the 64-bit {Hi,Lo} if the operand signs differ.
  - DIV: negate Lo if the signs differ; negate Hi if the dividend is negative.
  - Unsigned ops: no change.
  - DivZero <= Op[0] & (captured OpB==0).
- **DONE:** Done=1 for 1 cycle; Busy=0. Hi/Lo/DivZero hold until the next LOAD.
- **Latency:** Start sampled at edge t gives Done high in the cycle after edge t+34. Busy is high for 34 cycles.
- **ALU outputs when AluReq=0:** ALUControl=ADD, ALUA=0, ALUB=0.
- **Divide by zero:**
  - The algorithm runs unmodified: DIVU gives Lo=32'hFFFFFFFF, Hi=OpA.
  - DIV gives Hi=OpA, and Lo = OpA<0 ? 1 : 32'hFFFFFFFF.
  - DivZero=1.
- **DIV 32'h80000000 / 32'hFFFFFFFF:** Lo=32'h80000000, Hi=0. No trap.
- **Arithmetic:** all arithmetic is modulo 2^32 per register; the carry and borrow bits are the only 33rd bits kept.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU opcode constants: ALU_AND 5'b00000, ALU_OR 5'b00001, ALU_ADD 5'b00010, ALU_SUB 5'b00110, ALU_SLT 5'b00111.
  - Op encodings: OP_MULTU, OP_DIVU, OP_MULT, OP_DIV.
  - State encoding.
- One sub-module is natural: md_sign_fix, a combinational abs/negate helper for 32- and 64-bit values, used in IDLE capture and in FIX.

Test Plan:
- **MULTU:** 32'hFFFFFFFF * 32'hFFFFFFFF -> Done at t+35; Hi=32'hFFFFFFFE, Lo=32'h00000001; AluReq high exactly 32 cycles, ALUControl=00010 throughout.
- **MULT:** -3 * 7 -> Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB. MULT 0 * 32'h80000000 -> Hi=Lo=0.
- **DIVU/DIV values:**
  - DIVU 100 / 7 -> Lo=14, Hi=2; ALUControl=00110 during RUN.
  - DIV -7 / 2 -> Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF.
  - DIVU 32'hFFFFFFFF / 1 -> Lo=32'hFFFFFFFF, Hi=0.
- **Divide by zero:** DIVU 5 / 0 -> DivZero=1, Lo=32'hFFFFFFFF, Hi=5. DIV -5 / 0 -> Lo=1, Hi=32'hFFFFFFFB.
- **Handshake:**
  - Start re-pulsed while Busy -> ignored, the result is unchanged.
  - Start held high during the DONE cycle -> a new op begins and Busy rises next cycle.
  - Hi/Lo stay stable in IDLE.
- **Reset mid-operation:** Rst_n low at RUN Cnt=10 -> immediately Busy=0, Hi=Lo=0, AluReq=0, and no Done follows. A fresh op afterwards yields correct results.

Source files
------------

// File: rtl/mult_div_sequencer_pkg.sv
// Shared constants for the multiply/divide sequencer: ALU opcodes, operation
// encodings and the controller state encoding.
package alu_ctrl_pkg;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/mult_div_sequencer_if.sv
// Request/result and shared-ALU signals of the multiply/divide sequencer.
// master = requester plus ALU side, slave = the sequencer itself.
interface mult_div_sequencer_if;
  import alu_ctrl_pkg::*;

  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        AluReq;
  logic [4:0]  ALUControl;
  logic [31:0] ALUA;
  logic [31:0] ALUB;
  logic [31:0] ALUResult;
  state_t      dbg_state;

  modport master (
    output Start, Op, OpA, OpB, ALUResult,
    input  Busy, Done, DivZero, Hi, Lo, AluReq, ALUControl, ALUA, ALUB, dbg_state
  );

  modport slave (
    input  Start, Op, OpA, OpB, ALUResult,
    output Busy, Done, DivZero, Hi, Lo, AluReq, ALUControl, ALUA, ALUB, dbg_state
  );

endinterface

// File: rtl/mult_div_sequencer_sign_fix.sv
// Combinational two's-complement abs/negate helper: two 32-bit lanes and one
// 64-bit lane, each negated only when its enable is set.
module md_sign_fix (
  input  logic [31:0] a,
  input  logic        neg_a,
  input  logic [31:0] b,
  input  logic        neg_b,
  input  logic [63:0] w,
  input  logic        neg_w,
  output logic [31:0] a_fix,
  output logic [31:0] b_fix,
  output logic [63:0] w_fix
);

  assign a_fix = neg_a ? (~a + 32'd1) : a;
  assign b_fix = neg_b ? (~b + 32'd1) : b;
  assign w_fix = neg_w ? (~w + 64'd1) : w;

endmodule

// File: rtl/mult_div_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller that borrows the shared 32-bit
// ALU for 32 shift-add / restoring-subtract iterations and owns HI/LO.
module mult_div_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input logic                 Clk,
  input logic                 Rst_n,
  mult_div_sequencer_if.slave bus
);

  // Handshake: Start is sampled only when not Busy (IDLE or DONE); Busy is
  // high through LOAD/RUN/FIX; Done pulses for one cycle with Hi/Lo/DivZero
  // valid, and those hold until the next accepted Start reaches LOAD.

  localparam int CW = $clog2(ITER);

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic             sign_a, sign_b, b_zero;
  logic [WIDTH-1:0] m_q, q_q, hi_q, lo_q;
  logic             dz_q;
  logic [CW-1:0]    cnt;

  logic             is_div, is_signed, in_fix, last;
  logic [WIDTH-1:0] sf_a, sf_b, res_a, res_b;
  logic             sf_na, sf_nb, sf_nw;
  logic [2*WIDTH-1:0] res_w;
  logic [WIDTH-1:0] div_sh, alu_a, alu_b;
  logic [4:0]       alu_ctrl;
  logic             alu_req, carry, ge;

  assign is_div    = op_q[0];
  assign is_signed = op_q[1];
  assign in_fix    = (state == S_FIX);
  assign last      = (cnt == CW'(ITER - 1));

  // One helper serves both operand capture (IDLE/DONE) and the FIX pass.
  assign sf_a  = in_fix ? hi_q : bus.OpA;
  assign sf_na = in_fix ? (is_div & is_signed & sign_a) : (bus.Op[1] & bus.OpA[WIDTH-1]);
  assign sf_b  = in_fix ? lo_q : bus.OpB;
  assign sf_nb = in_fix ? (is_div & is_signed & (sign_a ^ sign_b))
                        : (bus.Op[1] & bus.OpB[WIDTH-1]);
  assign sf_nw = ~is_div & is_signed & (sign_a ^ sign_b);

  md_sign_fix u_sign_fix (
    .a     (sf_a),
    .neg_a (sf_na),
    .b     (sf_b),
    .neg_b (sf_nb),
    .w     ({hi_q, lo_q}),
    .neg_w (sf_nw),
    .a_fix (res_a),
    .b_fix (res_b),
    .w_fix (res_w)
  );

  // Low 32 bits of the shifted partial remainder {Hi, Lo[31]}; Hi[31] is its 33rd bit.
  assign div_sh = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign carry  = (bus.ALUResult < hi_q);
  assign ge     = hi_q[WIDTH-1] | (div_sh >= m_q);

  always_comb begin
    alu_req  = 1'b0;
    alu_ctrl = ALU_ADD;
    alu_a    = '0;
    alu_b    = '0;
    if (state == S_RUN) begin
      alu_req = 1'b1;
      if (is_div) begin
        alu_ctrl = ALU_SUB;
        alu_a    = div_sh;
        alu_b    = m_q;
      end else begin
        alu_a = hi_q;
        alu_b = lo_q[0] ? m_q : '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.Start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN:   if (last) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = bus.Start ? S_LOAD : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      m_q    <= '0;
      q_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dz_q   <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.Start) begin
            op_q   <= bus.Op;
            sign_a <= bus.OpA[WIDTH-1];
            sign_b <= bus.OpB[WIDTH-1];
            b_zero <= (bus.OpB == '0);
            m_q    <= res_b;
            q_q    <= res_a;
          end
        end
        S_LOAD: begin
          hi_q <= '0;
          lo_q <= q_q;
          dz_q <= 1'b0;
          cnt  <= '0;
        end
        S_RUN: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            hi_q <= ge ? bus.ALUResult : div_sh;
            lo_q <= {lo_q[WIDTH-2:0], ge};
          end else begin
            {hi_q, lo_q} <= {carry, bus.ALUResult, lo_q[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (!is_div && is_signed) begin
            {hi_q, lo_q} <= res_w;
          end else begin
            hi_q <= res_a;
            lo_q <= res_b;
          end
          dz_q <= is_div & b_zero;
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy       = (state == S_LOAD) || (state == S_RUN) || (state == S_FIX);
  assign bus.Done       = (state == S_DONE);
  assign bus.DivZero    = dz_q;
  assign bus.Hi         = hi_q;
  assign bus.Lo         = lo_q;
  assign bus.AluReq     = alu_req;
  assign bus.ALUControl = alu_ctrl;
  assign bus.ALUA       = alu_a;
  assign bus.ALUB       = alu_b;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: ALU model, arithmetic reference
// model with scoreboard queue, directed vectors with literal expectations.
module tb_mult_div_sequencer;
  import alu_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_div_sequencer_if bus ();

  mult_div_sequencer dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  // Shared ALU seen by the sequencer.
  always_comb begin
    case (bus.ALUControl)
      ALU_ADD: bus.ALUResult = bus.ALUA + bus.ALUB;
      ALU_SUB: bus.ALUResult = bus.ALUA - bus.ALUB;
      ALU_AND: bus.ALUResult = bus.ALUA & bus.ALUB;
      ALU_OR:  bus.ALUResult = bus.ALUA | bus.ALUB;
      ALU_SLT: bus.ALUResult = {31'b0, $signed(bus.ALUA) < $signed(bus.ALUB)};
      default: bus.ALUResult = 32'b0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Result packed as {DivZero, Hi, Lo}.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    logic [31:0] ua, ub, q, r;
    logic sgn;
    sgn = op[1];
    if (!op[0]) begin
      if (sgn) begin
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
      end else begin
        p = {32'b0, a} * {32'b0, b};
      end
      return {1'b0, p};
    end
    ua = (sgn && a[31]) ? (32'd0 - a) : a;
    ub = (sgn && b[31]) ? (32'd0 - b) : b;
    if (ub == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (sgn && (a[31] ^ b[31])) q = 32'd0 - q;
    if (sgn && a[31]) r = 32'd0 - r;
    return {ub == 32'd0, r, q};
  endfunction

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];
  logic [1:0]  sb_op_q[$];
  int          start_q[$];
  logic [64:0] held = '0;
  int          alu_cnt = 0;

  initial begin
    logic [64:0] e;
    logic [1:0]  cur_op;
    int          s;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held    = '0;
        alu_cnt = 0;
        continue;
      end
      if (bus.Busy || bus.Done) begin
        if (exp_q.size() == 0) begin
          check("spurious_busy_done", 65'({bus.Busy, bus.Done}), 65'd0);
        end else begin
          cur_op = sb_op_q[0];
          if (bus.AluReq) begin
            alu_cnt++;
            check("alu_ctrl_run", 65'(bus.ALUControl), 65'(cur_op[0] ? ALU_SUB : ALU_ADD));
          end else begin
            check("alu_rest_drive", 65'({bus.ALUControl, bus.ALUA, bus.ALUB}), 65'({ALU_ADD, 64'd0}));
          end
          if (bus.Done) begin
            e = exp_q.pop_front();
            void'(sb_op_q.pop_front());
            s = start_q.pop_front();
            check("model_hi", 65'(bus.Hi), 65'(e[63:32]));
            check("model_lo", 65'(bus.Lo), 65'(e[31:0]));
            check("model_divzero", 65'(bus.DivZero), 65'(e[64]));
            check("latency", 65'(cyc - s), 65'd34);
            check("alureq_cycles", 65'(alu_cnt), 65'd32);
            check("busy_in_done", 65'(bus.Busy), 65'd0);
            held    = e;
            alu_cnt = 0;
          end
        end
      end else begin
        check("hold_idle", {bus.DivZero, bus.Hi, bus.Lo}, held);
        check("alu_idle_drive", 65'({bus.AluReq, bus.ALUControl, bus.ALUA, bus.ALUB}),
              65'({1'b0, ALU_ADD, 64'd0}));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call at a negedge; the following posedge samples Start.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.OpA   = a;
    bus.OpB   = b;
    @(posedge clk);
    #1;
    exp_q.push_back(model(op, a, b));
    sb_op_q.push_back(op);
    start_q.push_back(cyc);
    bus.Start = 1'b0;
    bus.Op    = 2'($urandom_range(0, 3));
    bus.OpA   = $urandom;
    bus.OpB   = $urandom;
  endtask

  // Returns at the negedge where Done is seen.
  task automatic wait_done(input string name, input logic [31:0] hi, input logic [31:0] lo, input logic dz);
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.Done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL %s_timeout: Done=0 after 60 cycles, required 1", name);
    end else begin
      check({name, "_hi"}, 65'(bus.Hi), 65'(hi));
      check({name, "_lo"}, 65'(bus.Lo), 65'(lo));
      check({name, "_divzero"}, 65'(bus.DivZero), 65'(dz));
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input logic dz);
    @(negedge clk);
    start_op(op, a, b);
    wait_done(name, hi, lo, dz);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.Start = 1'b0;
    bus.Op    = 2'b00;
    bus.OpA   = 32'd0;
    bus.OpB   = 32'd0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 65'(bus.Busy), 65'd0);
    check("reset_done", 65'(bus.Done), 65'd0);
    check("reset_hilo", {bus.DivZero, bus.Hi, bus.Lo}, 65'd0);
    check("reset_alureq", 65'(bus.AluReq), 65'd0);
    check("reset_state", 65'(bus.dbg_state), 65'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg3x7", OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_zero",   OP_MULT,  32'd0,         32'h8000_0000, 32'd0,         32'd0,         1'b0);
    run_op("mult_minsq",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0);
    run_op("divu_100_7",  OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    run_op("div_neg7_2",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_7_neg2",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
    run_op("divu_max_1",  OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0);
    run_op("divu_5_0",    OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
    run_op("div_neg5_0",  OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'd1,         1'b1);
    run_op("div_min_m1",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);

    // Start re-pulsed while Busy must be ignored.
    @(negedge clk);
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    bus.Start = 1'b1;
    bus.Op    = OP_MULT;
    bus.OpA   = 32'd9;
    bus.OpB   = 32'd9;
    @(negedge clk);
    bus.Start = 1'b0;
    wait_done("repulse", 32'd2, 32'd14, 1'b0);
    repeat (3) @(negedge clk);

    // Start presented during the DONE cycle chains straight into LOAD.
    @(negedge clk);
    start_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done("chain_first", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("chain_busy", 65'(bus.Busy), 65'd1);
    wait_done("chain_second", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    repeat (3) @(negedge clk);

    // Reset in the middle of RUN (iteration 10).
    @(negedge clk);
    start_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (11) @(posedge clk);
    #2;
    check("pre_reset_alureq", 65'(bus.AluReq), 65'd1);
    rst_n = 1'b0;
    exp_q.delete();
    sb_op_q.delete();
    start_q.delete();
    #1;
    check("midreset_busy", 65'(bus.Busy), 65'd0);
    check("midreset_hilo", {bus.DivZero, bus.Hi, bus.Lo}, 65'd0);
    check("midreset_alureq", 65'(bus.AluReq), 65'd0);
    check("midreset_done", 65'(bus.Done), 65'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run_op("after_reset", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("after_reset_div", OP_DIVU, 32'd1000, 32'd33, 32'd10, 32'd30, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
